key_event_gen: RTL and testbench

- Consumes the per-bit debounced KEY[3:0] and SW[9:0] levels from the board debounce stage. Converts them into single-cycle event strobes and registered levels for user logic on the DE10-Standard.
- Per key: press, release, long-press and auto-repeat strobes.
- Per switch: a change strobe and a registered level.
- Sits directly downstream of the debounce stage, in the same clock domain.

---
 rtl/key_event_pkg.sv | 18 +
 rtl/key_event_chan.sv | 112 +++++++++++
 rtl/key_event_gen.sv | 87 ++++++++
 tb/tb_key_event_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg
//   Shared types and default constants for the key/switch event generator.
//   key_state_t : per-key FSM state (IDLE, HELD, REPEAT)
//   DEF_*       : default timing for a 50 MHz clock (1 s long-press,
//                 200 ms auto-repeat) and a hold-counter wide enough for both.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } key_state_t;

  localparam int DEF_LONG_CYCLES   = 50000000;
  localparam int DEF_REPEAT_CYCLES = 10000000;
  localparam int DEF_CNT_W         = 26;

endpackage

// File: rtl/key_event_chan.sv
// key_event_chan
//   One push-button channel: previous-sample register, press/release edge
//   detection, hold FSM with counter, and four registered one-cycle strobes.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset
//   primed_i   : high once the previous-sample register holds a real sample
//   key_n_i    : debounced key level, 0 = pressed
//   press_o    : strobe on press edge (from IDLE)
//   release_o  : strobe on release of a reported press
//   long_o     : strobe when the hold reaches LONG_CYCLES
//   repeat_o   : strobe every REPEAT_CYCLES after long_o while held
module key_event_chan
  import key_event_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic primed_i,
  input  logic key_n_i,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  key_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             prev_q;
  logic             press_q, release_q, long_q, repeat_q;

  logic press_edge_d, rel_edge_d;

  // Active-low input: 1 -> 0 is a press, 0 -> 1 is a release.
  assign press_edge_d = prev_q & ~key_n_i;
  assign rel_edge_d   = ~prev_q & key_n_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_q    <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      // The sample register always loads; on the priming edge it is the
      // only thing that happens, so no edge is ever seen against reset junk.
      prev_q    <= key_n_i;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      if (primed_i) begin
        unique case (state_q)
          IDLE: begin
            // A release edge here belongs to a press made before reset and
            // is deliberately ignored.
            if (press_edge_d) begin
              press_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= HELD;
            end
          end
          HELD: begin
            // Release is tested first so it wins over a long-press due now.
            if (rel_edge_d) begin
              release_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= IDLE;
            end else if (cnt_q == LONG_LAST) begin
              long_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= REPEAT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          REPEAT: begin
            if (rel_edge_d) begin
              release_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= IDLE;
            end else if (cnt_q == REPEAT_LAST) begin
              repeat_q <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen
//   Turns debounced KEY/SW levels into registered levels and one-cycle
//   event strobes for user logic. Same clock domain as the debouncer.
// Ports:
//   clk       : system clock (50 MHz)
//   reset     : synchronous active-high reset
//   iKEY      : debounced key levels, 0 = pressed
//   iSW       : debounced switch levels
//   oKEY_LVL  : registered pressed level, 1 = pressed
//   oPRESS    : per-key press strobe
//   oRELEASE  : per-key release strobe (only for a reported press)
//   oLONG     : per-key long-press strobe
//   oREPEAT   : per-key auto-repeat strobe
//   oSW_LVL   : registered switch levels
//   oSW_CHG   : per-switch change strobe
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int N_KEY         = 4,
  parameter int N_SW          = 10,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_KEY-1:0] iKEY,
  input  logic [N_SW-1:0]  iSW,
  output logic [N_KEY-1:0] oKEY_LVL,
  output logic [N_KEY-1:0] oPRESS,
  output logic [N_KEY-1:0] oRELEASE,
  output logic [N_KEY-1:0] oLONG,
  output logic [N_KEY-1:0] oREPEAT,
  output logic [N_SW-1:0]  oSW_LVL,
  output logic [N_SW-1:0]  oSW_CHG
);

  logic             primed_q;
  logic [N_KEY-1:0] key_lvl_q;
  logic [N_SW-1:0]  sw_prev_q;
  logic [N_SW-1:0]  sw_lvl_q;
  logic [N_SW-1:0]  sw_chg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      primed_q  <= 1'b0;
      key_lvl_q <= '0;
      sw_prev_q <= '0;
      sw_lvl_q  <= '0;
      sw_chg_q  <= '0;
    end else begin
      primed_q  <= 1'b1;
      sw_prev_q <= iSW;
      if (primed_q) begin
        key_lvl_q <= ~iKEY;
        sw_lvl_q  <= iSW;
        sw_chg_q  <= iSW ^ sw_prev_q;
      end else begin
        key_lvl_q <= '0;
        sw_lvl_q  <= '0;
        sw_chg_q  <= '0;
      end
    end
  end

  for (genvar g = 0; g < N_KEY; g++) begin : g_key
    key_event_chan #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .primed_i (primed_q),
      .key_n_i  (iKEY[g]),
      .press_o  (oPRESS[g]),
      .release_o(oRELEASE[g]),
      .long_o   (oLONG[g]),
      .repeat_o (oREPEAT[g])
    );
  end

  assign oKEY_LVL = key_lvl_q;
  assign oSW_LVL  = sw_lvl_q;
  assign oSW_CHG  = sw_chg_q;

endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen
//   Self-checking bench for key_event_gen with short timing
//   (LONG_CYCLES=8, REPEAT_CYCLES=4). Every clock is checked against a
//   hold-time reference model through an expected-result queue; a vector
//   table and hand-written sequences add explicit expectations.
module tb_key_event_gen;

  localparam int LONG  = 8;
  localparam int REP   = 4;
  localparam int CW    = 4;
  localparam int NK    = 4;
  localparam int NS    = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] iKEY = 4'hF;
  logic [NS-1:0] iSW = '0;
  logic [NK-1:0] oKEY_LVL, oPRESS, oRELEASE, oLONG, oREPEAT;
  logic [NS-1:0] oSW_LVL, oSW_CHG;

  always #5 clk = ~clk;

  key_event_gen #(
    .N_KEY(NK), .N_SW(NS), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .iKEY(iKEY), .iSW(iSW),
    .oKEY_LVL(oKEY_LVL), .oPRESS(oPRESS), .oRELEASE(oRELEASE),
    .oLONG(oLONG), .oREPEAT(oREPEAT), .oSW_LVL(oSW_LVL), .oSW_CHG(oSW_CHG)
  );

  typedef struct {
    logic [NK-1:0] lvl, press, rel, lng, rpt;
    logic [NS-1:0] swl, swc;
  } exp_t;

  typedef struct {
    logic [NK-1:0] key;
    logic [NS-1:0] sw;
    logic [NS-1:0] exp_chg;
    logic [NS-1:0] exp_lvl;
    logic [NK-1:0] exp_klvl;
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model state: hold time since press, not an FSM.
  bit            m_primed = 0;
  logic [NK-1:0] m_pk = '1;
  logic [NS-1:0] m_ps = '0;
  bit            m_act[NK];
  int            m_h[NK];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input logic [NK-1:0] k, input logic [NS-1:0] s, input logic r);
    exp_t e;
    exp_t got;
    iKEY = k; iSW = s; reset = r;
    e.lvl = '0; e.press = '0; e.rel = '0; e.lng = '0; e.rpt = '0;
    e.swl = '0; e.swc = '0;
    if (r) begin
      m_primed = 0;
      for (int i = 0; i < NK; i++) begin m_act[i] = 0; m_h[i] = 0; end
    end else if (!m_primed) begin
      m_primed = 1; m_pk = k; m_ps = s;
    end else begin
      e.lvl = ~k; e.swl = s; e.swc = s ^ m_ps;
      for (int i = 0; i < NK; i++) begin
        if (m_act[i] && !m_pk[i] && k[i]) begin
          e.rel[i] = 1'b1; m_act[i] = 0;
        end else if (!m_act[i] && m_pk[i] && !k[i]) begin
          e.press[i] = 1'b1; m_act[i] = 1; m_h[i] = 0;
        end else if (m_act[i]) begin
          m_h[i]++;
          if (m_h[i] == LONG) e.lng[i] = 1'b1;
          else if (m_h[i] > LONG && ((m_h[i] - LONG) % REP) == 0) e.rpt[i] = 1'b1;
        end
      end
      m_pk = k; m_ps = s;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    got = sb.pop_front();
    check("key_lvl", 32'(oKEY_LVL), 32'(got.lvl));
    check("press",   32'(oPRESS),   32'(got.press));
    check("release", 32'(oRELEASE), 32'(got.rel));
    check("long",    32'(oLONG),    32'(got.lng));
    check("repeat",  32'(oREPEAT),  32'(got.rpt));
    check("sw_lvl",  32'(oSW_LVL),  32'(got.swl));
    check("sw_chg",  32'(oSW_CHG),  32'(got.swc));
  endtask

  initial begin
    vec_t vt[8];
    int   acc, acc2, lvl_cnt;
    int   t_long[$];
    int   t_rep[$];
    int   t_rel[$];

    vt[0] = '{key: 4'hF, sw: 10'h000, exp_chg: 10'h000, exp_lvl: 10'h000, exp_klvl: 4'h0};
    vt[1] = '{key: 4'hF, sw: 10'h201, exp_chg: 10'h201, exp_lvl: 10'h201, exp_klvl: 4'h0};
    vt[2] = '{key: 4'hF, sw: 10'h200, exp_chg: 10'h001, exp_lvl: 10'h200, exp_klvl: 4'h0};
    vt[3] = '{key: 4'hF, sw: 10'h200, exp_chg: 10'h000, exp_lvl: 10'h200, exp_klvl: 4'h0};
    vt[4] = '{key: 4'hF, sw: 10'h3FF, exp_chg: 10'h1FF, exp_lvl: 10'h3FF, exp_klvl: 4'h0};
    vt[5] = '{key: 4'h0, sw: 10'h000, exp_chg: 10'h3FF, exp_lvl: 10'h000, exp_klvl: 4'hF};
    vt[6] = '{key: 4'hF, sw: 10'h000, exp_chg: 10'h000, exp_lvl: 10'h000, exp_klvl: 4'h0};
    vt[7] = '{key: 4'hA, sw: 10'h155, exp_chg: 10'h155, exp_lvl: 10'h155, exp_klvl: 4'h5};

    // Reset and idle.
    for (int i = 0; i < 3; i++) tick(4'hF, '0, 1'b1);
    check("rst_press", 32'(oPRESS), 32'h0);
    check("rst_lvl",   32'(oKEY_LVL), 32'h0);
    for (int i = 0; i < 5; i++) tick(4'hF, '0, 1'b0);
    check("idle_lvl", 32'(oKEY_LVL), 32'h0);

    // Short press on key 0.
    acc = 0; acc2 = 0; lvl_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(4'hE, '0, 1'b0);
      acc += int'(oPRESS[0]); acc2 += int'(oLONG[0]); lvl_cnt += int'(oKEY_LVL[0]);
    end
    tick(4'hF, '0, 1'b0);
    check("k0_release", 32'(oRELEASE[0]), 32'h1);
    lvl_cnt += int'(oKEY_LVL[0]);
    for (int i = 0; i < 3; i++) begin
      tick(4'hF, '0, 1'b0);
      acc2 += int'(oLONG[0]) + int'(oRELEASE[0]);
    end
    check("k0_press_cnt", 32'(acc), 32'd1);
    check("k0_lvl_cycles", 32'(lvl_cnt), 32'd3);
    check("k0_no_long", 32'(acc2), 32'd0);

    // Long hold on key 2: press at 0, long at 8, repeats at 12 and 16,
    // release at 20 suppresses the repeat due on the same edge.
    acc = 0;
    for (int i = 0; i < 21; i++) begin
      tick((i < 20) ? 4'hB : 4'hF, '0, 1'b0);
      if (i == 0) acc = int'(oPRESS[2]);
      if (oLONG[2]) t_long.push_back(i);
      if (oREPEAT[2]) t_rep.push_back(i);
      if (oRELEASE[2]) t_rel.push_back(i);
    end
    check("k2_press", 32'(acc), 32'd1);
    check("k2_long_n", 32'(t_long.size()), 32'd1);
    if (t_long.size() == 1) check("k2_long_t", 32'(t_long[0]), 32'd8);
    check("k2_rep_n", 32'(t_rep.size()), 32'd2);
    if (t_rep.size() == 2) begin
      check("k2_rep0_t", 32'(t_rep[0]), 32'd12);
      check("k2_rep1_t", 32'(t_rep[1]), 32'd16);
    end
    check("k2_rel_n", 32'(t_rel.size()), 32'd1);
    if (t_rel.size() == 1) check("k2_rel_t", 32'(t_rel[0]), 32'd20);
    for (int i = 0; i < 3; i++) tick(4'hF, '0, 1'b0);

    // Key 1 released exactly on the edge its long-press is due.
    acc = 0; acc2 = 0;
    for (int i = 0; i < 9; i++) begin
      tick((i < 8) ? 4'hD : 4'hF, '0, 1'b0);
      acc += int'(oLONG[1]); acc2 += int'(oRELEASE[1]);
    end
    for (int i = 0; i < 3; i++) begin
      tick(4'hF, '0, 1'b0);
      acc += int'(oLONG[1]) + int'(oREPEAT[1]);
    end
    check("k1_no_long", 32'(acc), 32'd0);
    check("k1_release", 32'(acc2), 32'd1);

    // Key 3 held across a reset: ignored until released and pressed again.
    for (int i = 0; i < 3; i++) tick(4'h7, '0, 1'b0);
    for (int i = 0; i < 2; i++) tick(4'h7, '0, 1'b1);
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      tick(4'h7, '0, 1'b0);
      acc += int'(oPRESS[3]) + int'(oRELEASE[3]) + int'(oLONG[3]) + int'(oREPEAT[3]);
    end
    for (int i = 0; i < 2; i++) begin
      tick(4'hF, '0, 1'b0);
      acc += int'(oPRESS[3]) + int'(oRELEASE[3]) + int'(oLONG[3]) + int'(oREPEAT[3]);
    end
    check("k3_silent", 32'(acc), 32'd0);
    tick(4'h7, '0, 1'b0);
    check("k3_repress", 32'(oPRESS[3]), 32'h1);
    tick(4'hF, '0, 1'b0);
    check("k3_release", 32'(oRELEASE[3]), 32'h1);
    for (int i = 0; i < 2; i++) tick(4'hF, '0, 1'b0);

    // Switch and simultaneous-key vector table.
    for (int i = 0; i < 8; i++) begin
      tick(vt[i].key, vt[i].sw, 1'b0);
      check("tbl_sw_chg", 32'(oSW_CHG), 32'(vt[i].exp_chg));
      check("tbl_sw_lvl", 32'(oSW_LVL), 32'(vt[i].exp_lvl));
      check("tbl_key_lvl", 32'(oKEY_LVL), 32'(vt[i].exp_klvl));
      if (i == 5) check("tbl_press_all", 32'(oPRESS), 32'hF);
      if (i == 6) check("tbl_rel_all", 32'(oRELEASE), 32'hF);
    end
    for (int i = 0; i < 4; i++) tick(4'hF, 10'h155, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
